// File: rtl/note_timer.sv
// note_timer: note-duration and articulation engine.
//
// Times the currently fetched score word against a live BPM and drives the
// 4-bit envelope for the tone stage. At note end it holds DONE high for
// DONE_HOLD cycles, which advances the score fetch. LOAD_WAIT PLAY-cycles later
// it samples the next NOTE/MODE.
//
// Ports:
//   CLK          system clock
//   RST_N        asynchronous active-low reset
//   BPM[7:0]     tempo, read live every cycle (0 is treated as 1)
//   MODE[1:0]    00 normal, 01 staccato, 10 slurred, 11 normal
//   NOTE[3:0]    note length in sixteenths, 0 = command word (no sound)
//   PLAY         1 run, 0 pause (everything freezes, VOL masked to 0)
//   VOL[3:0]     envelope level to the tone stage
//   DONE         note-end strobe. It is a level held DONE_HOLD active cycles,
//                with no back-pressure: downstream must sample it, not ack it
//   o_dbg_state  FSM state (0 LOAD, 1 SOUND, 2 DONE_ST)
//
// Optional build macro ENV_DECAY_EN: normal and slurred notes decay by one
// level per sixteenth, with a floor of 4. Staccato is unaffected.
module note_timer #(
  parameter int unsigned SUB_DIV   = 187500000,
  parameter int unsigned VOL_MAX   = 15,
  parameter int unsigned DONE_HOLD = 16,
  parameter int unsigned LOAD_WAIT = 32
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] BPM,
  input  logic [1:0] MODE,
  input  logic [3:0] NOTE,
  input  logic       PLAY,
  output logic [3:0] VOL,
  output logic       DONE,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SOUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int          WAIT_W = (LOAD_WAIT > 1) ? $clog2(LOAD_WAIT) : 1;
  localparam int          HOLD_W = $clog2(DONE_HOLD + 1);
  localparam logic [31:0] DIV    = 32'(SUB_DIV);
  localparam logic [3:0]  VMAX   = 4'(VOL_MAX);

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_acc, w_acc_nxt;
  logic [6:0]        r_sub_cnt, w_sub_cnt_nxt;
  logic [6:0]        r_total, w_total_nxt;
  logic [1:0]        r_md, w_md_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_nxt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
  logic [3:0]        r_vol, w_vol_nxt;
  logic              r_done, w_done_nxt;

  logic [7:0]        w_bpm_eff;
  logic [32:0]       w_sum;
  logic              w_stick;
  logic [3:0]        w_level;
  logic [3:0]        w_shape;

  // Sub-tick generator. acc stays below SUB_DIV, so the 33-bit sum cannot
  // overflow and the wrapped remainder always fits back into 32 bits.
  assign w_bpm_eff = (BPM == 8'd0) ? 8'd1 : BPM;
  assign w_sum     = {1'b0, r_acc} + {25'd0, w_bpm_eff};
  assign w_stick   = (r_state == ST_SOUND) && PLAY && (w_sum >= {1'b0, DIV});

  // Sounding level before articulation.
`ifdef ENV_DECAY_EN
  logic [4:0] w_decay;
  assign w_decay = {1'b0, VMAX} - {1'b0, r_sub_cnt[6:3]};
  always_comb begin
    w_level = VMAX;
    if (r_md != 2'b01) begin
      if (w_decay[4] || (w_decay[3:0] < 4'd4)) w_level = 4'd4;
      else                                      w_level = w_decay[3:0];
    end
  end
`else
  assign w_level = VMAX;
`endif

  // Articulation shape from the current sub-tick count. It is registered into
  // r_vol, so VOL trails a sub_cnt change by one cycle. total >= 8 whenever
  // this is used, so total-1 cannot underflow.
  always_comb begin
    w_shape = 4'd0;
    unique case (r_md)
      2'b01:   w_shape = (r_sub_cnt < {1'b0, r_total[6:1]}) ? w_level : 4'd0;
      2'b10:   w_shape = w_level;
      default: w_shape = (r_sub_cnt < (r_total - 7'd1)) ? w_level : 4'd0;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_sub_cnt_nxt = r_sub_cnt;
    w_total_nxt   = r_total;
    w_md_nxt      = r_md;
    w_wait_nxt    = r_wait_cnt;
    w_hold_nxt    = r_hold_cnt;
    w_vol_nxt     = 4'd0;
    w_done_nxt    = r_done;
    unique case (r_state)
      ST_LOAD: begin
        if (PLAY) begin
          if (r_wait_cnt == WAIT_W'(LOAD_WAIT - 1)) begin
            w_wait_nxt = '0;
            w_md_nxt   = MODE;
            if (NOTE == 4'd0) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_total_nxt   = {NOTE, 3'b000};
              w_sub_cnt_nxt = 7'd0;
              w_acc_nxt     = 32'd0;
              w_state_nxt   = ST_SOUND;
            end
          end else begin
            w_wait_nxt = r_wait_cnt + WAIT_W'(1);
          end
        end
      end
      ST_SOUND: begin
        w_vol_nxt = w_shape;
        if (PLAY) begin
          if (w_stick) begin
            w_acc_nxt     = w_sum[31:0] - DIV;
            w_sub_cnt_nxt = r_sub_cnt + 7'd1;
            if ((r_sub_cnt + 7'd1) == r_total) begin
              w_state_nxt = ST_DONE;
              w_vol_nxt   = 4'd0;
              w_hold_nxt  = '0;
            end
          end else begin
            w_acc_nxt = w_sum[31:0];
          end
        end
      end
      ST_DONE: begin
        // Completion does not wait for PLAY, so a pause can never stretch the
        // final edge. Hold counting before that point does freeze.
        if (r_hold_cnt == HOLD_W'(DONE_HOLD)) begin
          w_done_nxt  = 1'b0;
          w_hold_nxt  = '0;
          w_state_nxt = ST_LOAD;
        end else if (PLAY) begin
          w_done_nxt = 1'b1;
          w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_LOAD;
      r_acc      <= 32'd0;
      r_sub_cnt  <= 7'd0;
      r_total    <= 7'd0;
      r_md       <= 2'd0;
      r_wait_cnt <= '0;
      r_hold_cnt <= '0;
      r_vol      <= 4'd0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_sub_cnt  <= w_sub_cnt_nxt;
      r_total    <= w_total_nxt;
      r_md       <= w_md_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_vol      <= w_vol_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Pause mutes the tone stage at once, without waiting for a clock edge.
  assign VOL         = r_vol & {4{PLAY}};
  assign DONE        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_note_timer.sv
module tb_note_timer;

  localparam int SD = 800;
  localparam int DH = 4;
  localparam int LW = 8;
  localparam logic [1:0] ENC_LOAD = 2'd0;

  logic       CLK;
  logic       RST_N;
  logic [7:0] BPM;
  logic [1:0] MODE;
  logic [3:0] NOTE;
  logic       PLAY;
  logic [3:0] VOL;
  logic       DONE;
  logic [1:0] dbg_state;

  // Expected {DONE, VOL} after each clock edge of one note
  logic [4:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  note_timer #(
    .SUB_DIV  (SD),
    .VOL_MAX  (15),
    .DONE_HOLD(DH),
    .LOAD_WAIT(LW)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .BPM        (BPM),
    .MODE       (MODE),
    .NOTE       (NOTE),
    .PLAY       (PLAY),
    .VOL        (VOL),
    .DONE       (DONE),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Envelope level for a sounding note that has completed 'sub' sub-ticks.
  function automatic logic [3:0] exp_vol(input int mode, input int total, input int sub);
    int lvl;
    lvl = 15;
`ifdef ENV_DECAY_EN
    if (mode != 1) begin
      lvl = 15 - sub / 8;
      if (lvl < 4) lvl = 4;
    end
`endif
    case (mode)
      1:       return (sub < total / 2) ? 4'(lvl) : 4'd0;
      2:       return 4'(lvl);
      default: return (sub < total - 1) ? 4'(lvl) : 4'd0;
    endcase
  endfunction

  // Builds the expected trace from LOAD entry up to and including the edge
  // that returns to LOAD. The sub-tick count after n accumulates is just the
  // running BPM sum divided by SUB_DIV. BPM switches from b1 to b2 after
  // a_sw accumulates.
  task automatic build_trace(input int note, input int mode, input int b1,
                             input int b2, input int a_sw);
    int total, s_sum, sub_prev, sub_now, n, eff;
    exp_q.delete();
    for (int t = 0; t < LW; t++) exp_q.push_back(5'd0);
    if (note != 0) begin
      total    = note * 8;
      s_sum    = 0;
      sub_prev = 0;
      n        = 0;
      while (sub_prev < total) begin
        n++;
        eff = (n <= a_sw) ? b1 : b2;
        if (eff < 1) eff = 1;
        s_sum  += eff;
        sub_now = s_sum / SD;
        if (sub_now > total) sub_now = total;
        if (sub_now >= total) exp_q.push_back(5'd0);
        else                  exp_q.push_back({1'b0, exp_vol(mode, total, sub_prev)});
        sub_prev = sub_now;
      end
    end
    for (int i = 0; i < DH; i++) exp_q.push_back(5'b1_0000);
    exp_q.push_back(5'd0);
  endtask

  // ---------------- driver + scoreboard ----------------
  // Entered at a negedge just after the LOAD-entry edge. On return the bench
  // sits at the negedge just after the next LOAD-entry edge. pause_at is an
  // index into the unpaused trace (0 means no pause).
  task automatic play_note(input string tag, input int note, input int mode,
                           input int b1, input int b2, input int a_sw,
                           input int pause_at, input int pause_len);
    logic [4:0] exp_v;
    logic [4:0] obs;
    int t;
    int p_at;
    build_trace(note, mode, b1, b2, a_sw);
    p_at = (pause_at > exp_q.size() - 2) ? 0 : pause_at;
    NOTE = 4'(note);
    MODE = 2'(mode);
    BPM  = 8'(b1);
    PLAY = 1'b1;
    t    = 0;
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      exp_v = exp_q.pop_front();
      t++;
      obs = {DONE, VOL};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s t=%0d got done=%0b vol=%0d expected done=%0b vol=%0d",
                 tag, t, obs[4], obs[3:0], exp_v[4], exp_v[3:0]);
      end
      // The word is latched by now, so later changes must be ignored.
      if (t >= LW) begin
        NOTE = 4'($urandom_range(0, 15));
        MODE = 2'($urandom_range(0, 3));
      end
      if (t == LW + a_sw) BPM = 8'(b2);
      if (t == p_at) begin
        PLAY = 1'b0;
        for (int i = 0; i < pause_len; i++) begin
          @(negedge CLK);
          obs = {DONE, VOL};
          checks++;
          if (obs !== {exp_v[4], 4'd0}) begin
            errors++;
            $display("FAIL %s_pause i=%0d got done=%0b vol=%0d expected done=%0b vol=0",
                     tag, i, obs[4], obs[3:0], exp_v[4]);
          end
        end
        PLAY = 1'b1;
        #1;
        checks++;
        if (VOL !== exp_q[0][3:0]) begin
          errors++;
          $display("FAIL %s_resume got vol=%0d expected vol=%0d", tag, VOL, exp_q[0][3:0]);
        end
      end
    end
    checks++;
    if (dbg_state !== ENC_LOAD) begin
      errors++;
      $display("FAIL %s_end_state got %0d expected %0d", tag, dbg_state, ENC_LOAD);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_N = 1'b0;
    PLAY  = 1'b1;
    BPM   = 8'd80;
    NOTE  = 4'd4;
    MODE  = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if ({dbg_state, DONE, VOL} !== {ENC_LOAD, 1'b0, 4'd0}) begin
        errors++;
        $display("FAIL reset got state=%0d done=%0b vol=%0d expected state=0 done=0 vol=0",
                 dbg_state, DONE, VOL);
      end
    end
    RST_N = 1'b1;
  endtask

  task automatic test_normal();
    play_note("normal", 4, 0, 80, 80, 1000000, 0, 0);
  endtask

  task automatic test_staccato();
    play_note("staccato", 4, 1, 80, 80, 1000000, 0, 0);
  endtask

  task automatic test_command();
    play_note("command", 0, 3, 80, 80, 1000000, 0, 0);
  endtask

  task automatic test_pause();
    play_note("pause", 2, 2, 80, 80, 1000000, LW + 50, 100);
  endtask

  task automatic test_bpm_change();
    play_note("bpm_change", 3, 0, 80, 200, 40, 0, 0);
  endtask

  task automatic test_bpm_zero();
    play_note("bpm_zero", 1, 1, 0, 0, 1000000, 0, 0);
  endtask

  task automatic test_slur_long();
    play_note("slur8", 8, 2, 80, 80, 1000000, 0, 0);
  endtask

  task automatic test_back_to_back();
    int note, mode, b1, b2, a_sw, p_at, p_len;
    for (int k = 0; k < 8; k++) begin
      note  = $urandom_range(0, 15);
      mode  = $urandom_range(0, 3);
      b1    = $urandom_range(100, 255);
      b2    = ($urandom_range(0, 1) == 1) ? $urandom_range(50, 255) : b1;
      a_sw  = $urandom_range(1, 300);
      p_at  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 400) : 0;
      p_len = $urandom_range(1, 40);
      play_note("random", note, mode, b1, b2, a_sw, p_at, p_len);
    end
  endtask

  task automatic test_reset_mid_note();
    logic [3:0] exp_v;
    NOTE = 4'd8;
    MODE = 2'd0;
    BPM  = 8'd80;
    PLAY = 1'b1;
    repeat (LW + 100) @(negedge CLK);
    // 99 accumulates at BPM 80 have produced 9 sub-ticks of a 64 sub-tick note.
    exp_v = exp_vol(0, 64, 9);
    checks++;
    if (VOL !== exp_v) begin
      errors++;
      $display("FAIL mid_note_level got vol=%0d expected vol=%0d", VOL, exp_v);
    end
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({dbg_state, DONE, VOL} !== {ENC_LOAD, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL async_reset got state=%0d done=%0b vol=%0d expected state=0 done=0 vol=0",
               dbg_state, DONE, VOL);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    // A command word right after reset shows no leftover DONE from the aborted note.
    play_note("after_reset", 0, 0, 80, 80, 1000000, 0, 0);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_staccato();
    test_command();
    test_pause();
    test_bpm_change();
    test_bpm_zero();
    test_slur_long();
    test_back_to_back();
    test_reset_mid_note();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
